// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_pkg
// Description : Shared constants and state encoding for the UART deframer.
// Revision    : 1.0
// ============================================================================
package uart_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_LEN     = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_LINE    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_deframer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_deframer_if
// Description : Byte-in / payload-out handshake bundle of the UART deframer.
// Revision    : 1.0
// ============================================================================
interface uart_deframer_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       i_rxerr;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_last;
    logic       i_ready;
    logic       o_frame_ok;
    logic       o_err;
    logic [1:0] o_err_code;

    modport slave (
        input  i_data, i_valid, i_rxerr, i_ready,
        output o_ready, o_data, o_valid, o_last, o_frame_ok, o_err, o_err_code
    );

    modport master (
        output i_data, i_valid, i_rxerr, i_ready,
        input  o_ready, o_data, o_valid, o_last, o_frame_ok, o_err, o_err_code
    );
endinterface
`default_nettype wire

// File: rtl/uart_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_buf
// Description : DEPTH x 8 payload store, synchronous write, combinational read.
// Revision    : 1.0
// ============================================================================
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  wire logic          i_clk,
    input  wire logic          i_wr_en,
    input  wire logic [AW-1:0] i_wr_addr,
    input  wire logic [7:0]    i_wr_data,
    input  wire logic [AW-1:0] i_rd_addr,
    output logic [7:0]         o_rd_data
);
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule
`default_nettype wire

// File: rtl/uart_deframer.sv
`default_nettype none
// ============================================================================
// Module      : uart_deframer
// Description : Hunts SYNC/LEN/payload/CHK frames, verifies the checksum and
//               replays the buffered payload over a valid/ready stream.
// Revision    : 1.0
// ============================================================================
module uart_deframer #(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 100000
) (
    input  wire logic      i_clk,
    input  wire logic      i_rst,
    uart_deframer_if.slave bus
);
    import uart_frame_pkg::*;

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]    c_MAX_LEN = 8'(MAX_LEN);
    localparam logic [TW-1:0] c_TIMEOUT = TW'(TIMEOUT_CYC);

    state_t        r_state;
    logic [IW-1:0] r_len;
    logic [IW-1:0] r_wr_idx;
    logic [IW-1:0] r_rd_idx;
    logic [7:0]    r_sum;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_last;
    logic          r_frame_ok;
    logic          r_err;
    logic [1:0]    r_err_code;

    logic          w_ready;
    logic          w_accept;
    logic          w_wr_en;
    logic [IW-1:0] w_wr_next;
    logic [IW-1:0] w_rd_next;
    logic [IW-1:0] w_rd_addr;
    logic [TW-1:0] w_to_next;
    logic [7:0]    w_chk_sum;
    logic [7:0]    w_rd_data;

    assign w_ready   = (r_state != ST_DRAIN);
    assign w_accept  = bus.i_valid && w_ready;
    assign w_wr_en   = (r_state == ST_PAYLOAD) && w_accept && !bus.i_rxerr;
    assign w_wr_next = r_wr_idx + IW'(1);
    assign w_rd_next = r_rd_idx + IW'(1);
    assign w_to_next = r_to_cnt + TW'(1);
    assign w_chk_sum = r_sum + bus.i_data;
    // Byte 0 must be on the read port in the CHK cycle so it can load o_data.
    assign w_rd_addr = (r_state == ST_DRAIN) ? r_rd_idx : '0;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_idx[AW-1:0]),
        .i_wr_data (bus.i_data),
        .i_rd_addr (w_rd_addr[AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_HUNT;
            r_len      <= '0;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_sum      <= '0;
            r_to_cnt   <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_frame_ok <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_LEN;
        end else begin
            r_frame_ok <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (w_accept && bus.i_data == SYNC_BYTE) begin
                        r_state  <= ST_LEN;
                        r_to_cnt <= '0;
                    end
                end
                ST_LEN, ST_PAYLOAD, ST_CHK: begin
                    // Line error outranks a same-cycle byte; a byte outranks the timeout.
                    if (bus.i_rxerr) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_LINE;
                        r_state    <= ST_HUNT;
                        r_to_cnt   <= '0;
                    end else if (w_accept) begin
                        r_to_cnt <= '0;
                        if (r_state == ST_LEN) begin
                            if (bus.i_data == 8'h00 || bus.i_data > c_MAX_LEN) begin
                                r_err      <= 1'b1;
                                r_err_code <= ERR_LEN;
                                r_state    <= ST_HUNT;
                            end else begin
                                r_len    <= bus.i_data[IW-1:0];
                                r_sum    <= bus.i_data;
                                r_wr_idx <= '0;
                                r_state  <= ST_PAYLOAD;
                            end
                        end else if (r_state == ST_PAYLOAD) begin
                            r_sum    <= w_chk_sum;
                            r_wr_idx <= w_wr_next;
                            if (w_wr_next == r_len) begin
                                r_state <= ST_CHK;
                            end
                        end else if (w_chk_sum == 8'h00) begin
                            r_frame_ok <= 1'b1;
                            r_state    <= ST_DRAIN;
                            r_valid    <= 1'b1;
                            r_data     <= w_rd_data;
                            r_last     <= (r_len == IW'(1));
                            r_rd_idx   <= IW'(1);
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_CHK;
                            r_state    <= ST_HUNT;
                        end
                    end else if (w_to_next == c_TIMEOUT) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                        r_state    <= ST_HUNT;
                        r_to_cnt   <= '0;
                    end else begin
                        r_to_cnt <= w_to_next;
                    end
                end
                ST_DRAIN: begin
                    if (r_valid && bus.i_ready) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= ST_HUNT;
                        end else begin
                            r_data   <= w_rd_data;
                            r_last   <= (w_rd_next == r_len);
                            r_rd_idx <= w_rd_next;
                        end
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

    assign bus.o_ready    = w_ready;
    assign bus.o_data     = r_data;
    assign bus.o_valid    = r_valid;
    assign bus.o_last     = r_last;
    assign bus.o_frame_ok = r_frame_ok;
    assign bus.o_err      = r_err;
    assign bus.o_err_code = r_err_code;
endmodule
`default_nettype wire

// File: tb/tb_uart_deframer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_deframer
// Description : Directed self-checking bench for uart_deframer.
// Revision    : 1.0
// ============================================================================
module tb_uart_deframer;
    localparam int MAX_LEN     = 16;
    localparam int TIMEOUT_CYC = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    uart_deframer_if bus();

    uart_deframer #(
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_data  = b;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic l);
        chk({tag, ".valid"}, 16'(bus.o_valid), 16'(v));
        chk({tag, ".data"},  16'(bus.o_data),  16'(d));
        chk({tag, ".last"},  16'(bus.o_last),  16'(l));
    endtask

    initial begin
        bus.i_data  = 8'h00;
        bus.i_valid = 1'b0;
        bus.i_rxerr = 1'b0;
        bus.i_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst.ready", 16'(bus.o_ready), 16'd1);
        chk_out("rst", 1'b0, 8'h00, 1'b0);
        chk("rst.ok", 16'(bus.o_frame_ok), 16'd0);
        chk("rst.err", 16'(bus.o_err), 16'd0);
        chk("rst.code", 16'(bus.o_err_code), 16'd0);
        rst = 1'b0;
        tick();

        // Good frame, consumer always ready
        send(8'hA5); send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'hF7);
        chk("a.ok", 16'(bus.o_frame_ok), 16'd1);
        chk("a.ready_drain", 16'(bus.o_ready), 16'd0);
        chk_out("a.b0", 1'b1, 8'h01, 1'b0);
        tick();
        chk("a.ok_pulse", 16'(bus.o_frame_ok), 16'd0);
        chk_out("a.b1", 1'b1, 8'h02, 1'b0);
        tick();
        chk_out("a.b2", 1'b1, 8'h03, 1'b1);
        tick();
        chk("a.end_valid", 16'(bus.o_valid), 16'd0);
        chk("a.end_ready", 16'(bus.o_ready), 16'd1);

        // Bad checksum
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
        chk("b.err", 16'(bus.o_err), 16'd1);
        chk("b.code", 16'(bus.o_err_code), 16'd1);
        chk("b.valid", 16'(bus.o_valid), 16'd0);
        tick();
        chk("b.err_pulse", 16'(bus.o_err), 16'd0);
        chk("b.valid2", 16'(bus.o_valid), 16'd0);
        chk("b.ready", 16'(bus.o_ready), 16'd1);

        // Junk, zero length, then a one-byte frame
        send(8'h55); send(8'hA5); send(8'h00);
        chk("c.err", 16'(bus.o_err), 16'd1);
        chk("c.code", 16'(bus.o_err_code), 16'd0);
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
        chk("c.ok", 16'(bus.o_frame_ok), 16'd1);
        chk_out("c.b0", 1'b1, 8'h7F, 1'b1);
        tick();
        chk("c.end_valid", 16'(bus.o_valid), 16'd0);

        // Length above MAX_LEN
        send(8'hA5); send(8'h11);
        chk("l.err", 16'(bus.o_err), 16'd1);
        chk("l.code", 16'(bus.o_err_code), 16'd0);

        // Inter-byte timeout: error exactly TIMEOUT_CYC cycles after the last byte
        send(8'hA5); send(8'h03); send(8'h01);
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) tick();
        chk("t.early", 16'(bus.o_err), 16'd0);
        tick();
        chk("t.err", 16'(bus.o_err), 16'd1);
        chk("t.code", 16'(bus.o_err_code), 16'd2);

        // Line error together with a byte
        send(8'hA5); send(8'h02); send(8'hAA);
        bus.i_rxerr = 1'b1;
        send(8'hBB);
        bus.i_rxerr = 1'b0;
        chk("r.err", 16'(bus.o_err), 16'd1);
        chk("r.code", 16'(bus.o_err_code), 16'd3);
        chk("r.ready", 16'(bus.o_ready), 16'd1);
        tick();
        chk("r.valid", 16'(bus.o_valid), 16'd0);
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
        chk("r.ok", 16'(bus.o_frame_ok), 16'd1);
        chk_out("r.b0", 1'b1, 8'h7F, 1'b1);
        tick();

        // Back-pressure: data held across stalls
        send(8'hA5); send(8'h03); send(8'h01); send(8'h02); send(8'h03);
        bus.i_ready = 1'b0;
        send(8'hF7);
        chk_out("s.b0", 1'b1, 8'h01, 1'b0);
        tick();
        chk_out("s.b0_hold", 1'b1, 8'h01, 1'b0);
        bus.i_ready = 1'b1; tick();
        chk_out("s.b1", 1'b1, 8'h02, 1'b0);
        bus.i_ready = 1'b0; tick();
        chk_out("s.b1_hold", 1'b1, 8'h02, 1'b0);
        bus.i_ready = 1'b1; tick();
        chk_out("s.b2", 1'b1, 8'h03, 1'b1);
        bus.i_ready = 1'b0; tick();
        chk_out("s.b2_hold", 1'b1, 8'h03, 1'b1);
        bus.i_ready = 1'b1; tick();
        chk("s.end_valid", 16'(bus.o_valid), 16'd0);
        chk("s.no_err", 16'(bus.o_err), 16'd0);

        // Reset mid-frame: discarded silently
        send(8'hA5); send(8'h02); send(8'h11);
        rst = 1'b1;
        tick();
        chk("m.err", 16'(bus.o_err), 16'd0);
        chk("m.ready", 16'(bus.o_ready), 16'd1);
        rst = 1'b0;
        tick();
        chk("m.err2", 16'(bus.o_err), 16'd0);
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
        chk("m.ok", 16'(bus.o_frame_ok), 16'd1);
        chk_out("m.b0", 1'b1, 8'h7F, 1'b1);
        tick();

        // Reset mid-drain
        bus.i_ready = 1'b0;
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
        chk("d.valid", 16'(bus.o_valid), 16'd1);
        rst = 1'b1;
        tick();
        chk_out("d.rst", 1'b0, 8'h00, 1'b0);
        chk("d.err", 16'(bus.o_err), 16'd0);
        chk("d.ready", 16'(bus.o_ready), 16'd1);
        rst = 1'b0;
        bus.i_ready = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
